// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter: shares one synchronous memory port between two requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating tie grants (else port 0 wins).
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              owner,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       any_req;
  logic       winner;
  logic       timed_out;

  always_comb begin
    any_req = m0_req | m1_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that did not hold the last grant goes next.
    winner  = (m0_req & m1_req) ? ~owner : m1_req;
`else
    winner  = m1_req & ~m0_req;
`endif
  end

  // Counter holds the number of BUSY cycles already spent without mem_ready.
  assign timed_out = (wait_cnt + 8'd1) == TIMEOUT_CNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ready || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      owner     <= 1'b1;
      err       <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            mem_valid <= 1'b1;
            mem_addr  <= winner ? m1_addr  : m0_addr;
            mem_wdata <= winner ? m1_wdata : m0_wdata;
            mem_write <= winner ? m1_write : m0_write;
            wait_cnt  <= 8'd0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_write) begin
              if (owner) m1_rdata <= mem_rdata;
              else       m0_rdata <= mem_rdata;
            end
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            m0_ready  <= ~owner;
            m1_ready  <= owner;
          end else if (timed_out) begin
            err       <= 1'b1;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            m0_ready  <= ~owner;
            m1_ready  <= owner;
          end else begin
            wait_cnt  <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
        end
        default: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter: directed vector table plus multi-cycle corner sequences.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_write, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_write, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_valid, mem_write, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner, err;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_write (m0_write),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_write (m1_write),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .owner    (owner),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rst, r0, a0, w0, d0, r1, a1, w1, d1, mrdy, mrd;
    logic [31:0] v, mw, ma, md, y0, y1, rd0, rd1, own, err;
  } vec_t;

  vec_t        vecs [14];
  int          assertions = 0;
  int          failures   = 0;
  logic [31:0] exp_rd0, exp_rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst[0];
    m0_req    = v.r0[0];
    m0_addr   = v.a0;
    m0_write  = v.w0[0];
    m0_wdata  = v.d0;
    m1_req    = v.r1[0];
    m1_addr   = v.a1;
    m1_write  = v.w1[0];
    m1_wdata  = v.d1;
    mem_ready = v.mrdy[0];
    mem_rdata = v.mrd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    check($sformatf("row%0d mem_valid", i), {31'b0, mem_valid}, v.v);
    check($sformatf("row%0d mem_write", i), {31'b0, mem_write}, v.mw);
    check($sformatf("row%0d mem_addr", i),  mem_addr,            v.ma);
    check($sformatf("row%0d mem_wdata", i), mem_wdata,           v.md);
    check($sformatf("row%0d m0_ready", i),  {31'b0, m0_ready},  v.y0);
    check($sformatf("row%0d m1_ready", i),  {31'b0, m1_ready},  v.y1);
    check($sformatf("row%0d m0_rdata", i),  m0_rdata,            v.rd0);
    check($sformatf("row%0d m1_rdata", i),  m1_rdata,            v.rd1);
    check($sformatf("row%0d owner", i),     {31'b0, owner},     v.own);
    check($sformatf("row%0d err", i),       {31'b0, err},       v.err);
  endtask

  initial begin
    // {rst,r0,a0,w0,d0, r1,a1,w1,d1, mrdy,mrd,  v,mw,ma,md, y0,y1, rd0,rd1, own,err}
    vecs[0]  = '{1,0,0,0,0, 0,0,0,0, 0,0,                   0,0,0,0, 0,0, 0,0, 1,0};
    vecs[1]  = '{0,0,0,0,0, 0,0,0,0, 1,'hFFFFFFFF,          0,0,0,0, 0,0, 0,0, 1,0};
    vecs[2]  = '{0,1,'h10,0,0, 0,0,0,0, 0,0,                1,0,'h10,0, 0,0, 0,0, 0,0};
    vecs[3]  = '{0,1,'h10,0,0, 0,0,0,0, 0,0,                1,0,'h10,0, 0,0, 0,0, 0,0};
    vecs[4]  = '{0,1,'h10,0,0, 0,0,0,0, 1,'hDEADBEEF,       0,0,'h10,0, 1,0, 'hDEADBEEF,0, 0,0};
    vecs[5]  = '{0,1,'h10,0,0, 0,0,0,0, 0,0,                0,0,'h10,0, 0,0, 'hDEADBEEF,0, 0,0};
    vecs[6]  = '{0,0,0,0,0, 1,'h40,1,'h12345678, 0,0,       1,1,'h40,'h12345678, 0,0, 'hDEADBEEF,0, 1,0};
    vecs[7]  = '{0,0,0,0,0, 1,'h40,1,'h12345678, 0,'hAAAA5555, 1,1,'h40,'h12345678, 0,0, 'hDEADBEEF,0, 1,0};
    vecs[8]  = '{0,0,0,0,0, 1,'h40,1,'h12345678, 1,'hAAAA5555, 0,0,'h40,'h12345678, 0,1, 'hDEADBEEF,0, 1,0};
    vecs[9]  = '{0,0,0,0,0, 1,'h40,1,'h12345678, 0,0,       0,0,'h40,'h12345678, 0,0, 'hDEADBEEF,0, 1,0};
    vecs[10] = '{0,0,0,0,0, 1,'h44,0,0, 0,0,                1,0,'h44,0, 0,0, 'hDEADBEEF,0, 1,0};
    vecs[11] = '{0,0,0,0,0, 1,'h44,0,0, 1,'h0BADF00D,       0,0,'h44,0, 0,1, 'hDEADBEEF,'h0BADF00D, 1,0};
    vecs[12] = '{0,0,0,0,0, 1,'h44,0,0, 0,0,                0,0,'h44,0, 0,0, 'hDEADBEEF,'h0BADF00D, 1,0};
    vecs[13] = '{0,0,0,0,0, 0,0,0,0, 1,'h12,                0,0,'h44,0, 0,0, 'hDEADBEEF,'h0BADF00D, 1,0};

    drive(vecs[0]);
    tick;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      tick;
      check_row(i, vecs[i]);
    end
    exp_rd0 = 32'hDEADBEEF;
    exp_rd1 = 32'h0BADF00D;

    // Both ports request continuously against zero-wait memory.
    m0_req = 1'b1; m0_addr = 32'h100; m0_write = 1'b0; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_write = 1'b0; m1_wdata = 32'h0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic        g;
      logic [31:0] val;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      g = i[0];
`else
      g = 1'b0;
`endif
      val = 32'hC0DE0000 + 32'(i);
      mem_rdata = val;
      tick;
      check($sformatf("tie%0d owner", i), {31'b0, owner}, {31'b0, g});
      check($sformatf("tie%0d mem_valid", i), {31'b0, mem_valid}, 32'd1);
      check($sformatf("tie%0d mem_addr", i), mem_addr, g ? 32'h200 : 32'h100);
      tick;
      check($sformatf("tie%0d win_ready", i), {31'b0, g ? m1_ready : m0_ready}, 32'd1);
      check($sformatf("tie%0d lose_ready", i), {31'b0, g ? m0_ready : m1_ready}, 32'd0);
      check($sformatf("tie%0d rdata", i), g ? m1_rdata : m0_rdata, val);
      if (g) exp_rd1 = val;
      else   exp_rd0 = val;
      tick;
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0;
    tick;

    // Timeout with memory never answering.
    m0_req = 1'b1; m0_addr = 32'h80; mem_rdata = 32'h77777777;
    tick;
    check("to grant valid", {31'b0, mem_valid}, 32'd1);
    check("to grant owner", {31'b0, owner}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("to busy%0d valid", i), {31'b0, mem_valid}, 32'd1);
      check($sformatf("to busy%0d err", i), {31'b0, err}, 32'd0);
      check($sformatf("to busy%0d ready", i), {31'b0, m0_ready}, 32'd0);
    end
    tick;
    check("to valid drop", {31'b0, mem_valid}, 32'd0);
    check("to err set", {31'b0, err}, 32'd1);
    check("to m0_ready", {31'b0, m0_ready}, 32'd1);
    check("to m1_ready", {31'b0, m1_ready}, 32'd0);
    check("to m0_rdata", m0_rdata, exp_rd0);
    tick;
    m0_req = 1'b0;
    check("to ready end", {31'b0, m0_ready}, 32'd0);
    tick;
    tick;
    check("to err sticky", {31'b0, err}, 32'd1);
    check("to idle valid", {31'b0, mem_valid}, 32'd0);
    check("to m1_rdata", m1_rdata, exp_rd1);

    // Reset asserted during the second BUSY cycle.
    m1_req = 1'b1; m1_addr = 32'h300; m1_write = 1'b0;
    tick;
    check("rb grant valid", {31'b0, mem_valid}, 32'd1);
    check("rb grant owner", {31'b0, owner}, 32'd1);
    tick;
    check("rb busy2 valid", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0; m1_req = 1'b0;
    tick;
    check("rb valid", {31'b0, mem_valid}, 32'd0);
    check("rb m1_ready", {31'b0, m1_ready}, 32'd0);
    check("rb m1_rdata", m1_rdata, 32'd0);
    check("rb m0_rdata", m0_rdata, 32'd0);
    check("rb err", {31'b0, err}, 32'd0);
    check("rb owner", {31'b0, owner}, 32'd1);
    check("rb mem_addr", mem_addr, 32'd0);
    rst = 1'b0; mem_ready = 1'b0;
    tick;
    check("rb after ready", {31'b0, m1_ready}, 32'd0);
    check("rb after valid", {31'b0, mem_valid}, 32'd0);
    m0_req = 1'b1; m0_addr = 32'h20; m0_write = 1'b0;
    tick;
    check("rb new valid", {31'b0, mem_valid}, 32'd1);
    check("rb new owner", {31'b0, owner}, 32'd0);
    check("rb new addr", mem_addr, 32'h20);
    mem_ready = 1'b1; mem_rdata = 32'h600DCAFE;
    tick;
    check("rb new ready", {31'b0, m0_ready}, 32'd1);
    check("rb new rdata", m0_rdata, 32'h600DCAFE);
    m0_req = 1'b0; mem_ready = 1'b0;
    tick;
    check("rb new end", {31'b0, m0_ready}, 32'd0);
    check("rb new idle", {31'b0, mem_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single synchronous memory port (addr/wdata/write/rdata/ready) between two requesters: port 0 for the multi-cycle CPU and port 1 for the program loader / debug host. It accepts one transaction at a time and forwards it to memory, holding the memory signals stable until memory asserts `mem_ready`. It then returns read data and a one-cycle completion pulse to the owning requester. Sits between the requesters and the shared instruction/data memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles waiting for `mem_ready` before abort; 8-bit counter
- `clk`  in  1  clock
- `rst`  in  1  **reset, synchronous, active-high**
- `m0_req`  in  1  port-0 request; held until `m0_ready`
- `m0_addr`  in  ADDR_W  port-0 address
- `m0_wdata`  in  DATA_W  port-0 write data
- `m0_write`  in  1  port-0 write (1) / read (0)
- `m0_rdata`  out  DATA_W  port-0 read data, registered
- `m0_ready`  out  1  port-0 completion pulse
- `m1_req`, `m1_addr`, `m1_wdata`, `m1_write`, `m1_rdata`, `m1_ready`: same as port 0, for port 1
- `mem_valid`  out  1  transaction active on memory
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_write`  out  1  memory write strobe, valid only with `mem_valid`
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ready`  in  1  memory completion, sampled only in BUSY
- `owner`  out  1  port currently or last granted
- `err`  out  1  sticky timeout flag; cleared only by `rst`

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner and register its addr/wdata/write into `mem_*`.
  - Set `owner` to the winner, `mem_valid`=1, clear the timeout counter, go to BUSY.
- BUSY:
  - `mem_*` are held stable.
  - If `mem_ready`=1: capture `mem_rdata` into the owner's rdata register (reads only; writes leave rdata unchanged). Drop `mem_valid` and `mem_write`, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, set `err`=1, drop `mem_valid`, and go to RESP; rdata is left unchanged.
- RESP: pulse the owner's `mN_ready`=1 for exactly one cycle, then go to IDLE.
- The non-owner's `ready` is never asserted.
- A requester's `req` may change only on the edge where it samples its `ready`=1. Requests raised while another transaction is in progress wait in IDLE arbitration.
- `mem_ready` outside BUSY is ignored.
- Reset values: `mem_valid`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `m0_rdata`=`m1_rdata`=0, `m0_ready`=`m1_ready`=0, `owner`=1 (so port 0 wins the first tie under round-robin), `err`=0, state IDLE.
- `rst` during BUSY or RESP aborts the transaction: no `ready` pulse and no rdata update, and all outputs take their reset values on that edge.

## Timing
- Request seen in IDLE at cycle t: `mem_valid`=1 from t+1.
- `mem_ready` sampled at cycle k: `mN_ready`=1 and `mN_rdata` valid at k+1; back in IDLE at k+2.
- Minimum turnaround with zero-wait memory (`mem_ready` high in the first BUSY cycle): 3 cycles per transaction.
- A new grant can issue in the cycle right after RESP; no dead cycle beyond IDLE.
- Simultaneous requests in IDLE are resolved per Configuration. A lone request wins regardless of priority.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port other than `owner` wins (alternating grants).
- Not defined: fixed priority, port 0 always wins ties. Port 1 can be starved by continuous port-0 traffic, which is accepted behaviour.

## Test plan
- Single read, port 0: `m0_addr`=0x10, memory returns 0xDEADBEEF with `mem_ready` two cycles after `mem_valid` -> `m0_ready` pulse one cycle later, `m0_rdata`=0xDEADBEEF, `m1_ready` stays 0.
- Port-1 write: `m1_addr`=0x40, `m1_wdata`=0x12345678, `m1_write`=1 -> `mem_addr`=0x40, `mem_wdata`=0x12345678, `mem_write`=1 held until `mem_ready`; `m1_ready` pulses; `m1_rdata` unchanged.
- Tie, both req held for 4 transactions, zero-wait memory:
  - With `MEM_ARB_ROUND_ROBIN_EN`: grant order 0,1,0,1.
  - Without it: order 0,0,0,0 while `m0_req` stays high.
- Timeout: `TIMEOUT`=4, `mem_ready` never asserted -> `mem_valid` drops after 4 BUSY cycles, `err`=1, owner `ready` pulses, rdata unchanged; `err` stays 1 until `rst`.
- Reset mid-BUSY: `rst` asserted in the second BUSY cycle -> next edge `mem_valid`=0, no `ready` pulse, state IDLE, a later request is served normally.
- Spurious `mem_ready` in IDLE with no requests -> no output changes.
